// File: rtl/stopwatch_pkg.sv
// Shared types and BCD limits for the stopwatch control block.
package stopwatch_pkg;
    typedef enum logic [1:0] {IDLE, RUN, PAUSE, LAP} state_t;

    localparam logic [3:0]  CS_TENS_MAX   = 4'd9;
    localparam logic [3:0]  SEC_TENS_MAX  = 4'd5;
    localparam logic [3:0]  MIN_TENS_MAX  = 4'd5;
    localparam logic [23:0] TIME_MAX      = 24'h59_59_99;
    localparam logic [23:0] TIME_NEAR_MAX = 24'h59_59_98;
endpackage

// File: rtl/stopwatch_ctrl_if.sv
// Tick/button inputs and display-side outputs of the stopwatch controller.
interface stopwatch_ctrl_if;
    logic       tick;
    logic       start_stop;
    logic       lap;
    logic       clear;
    logic       running;
    logic       lap_frozen;
    logic [7:0] disp_m;
    logic [7:0] disp_s;
    logic [7:0] disp_cs;
    logic       ovf;

    modport master (output tick, start_stop, lap, clear,
                    input  running, lap_frozen, disp_m, disp_s, disp_cs, ovf);
    modport slave  (input  tick, start_stop, lap, clear,
                    output running, lap_frozen, disp_m, disp_s, disp_cs, ovf);
endinterface

// File: rtl/stopwatch_ctrl_bcd.sv
// Two-digit BCD counter {tens, ones}; tens limited to TENS_MAX, ones to 9.
module bcd_counter_2dig
    import stopwatch_pkg::*;
#(
    parameter logic [3:0] TENS_MAX = CS_TENS_MAX
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clr,
    input  logic       inc,
    input  logic       sat,
    output logic [7:0] q,
    output logic       carry
);
    logic at_top;

    assign at_top = (q == {TENS_MAX, 4'd9});
    assign carry  = inc & at_top;

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            q <= 8'h00;
        end else if (inc) begin
            // sat holds the top value instead of rolling over
            if (at_top) begin
                if (!sat) q <= 8'h00;
            end else if (q[3:0] == 4'd9) begin
                q <= {q[7:4] + 4'd1, 4'd0};
            end else begin
                q <= {q[7:4], q[3:0] + 4'd1};
            end
        end
    end
endmodule

// File: rtl/stopwatch_ctrl.sv
// Start/stop/lap/clear FSM, BCD mm:ss.cc timekeeping, lap freeze and display mux.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter bit WRAP_AT_MAX = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    stopwatch_ctrl_if.slave  sw
);
    state_t      state, state_nx;
    logic        prev_ss, prev_lap, prev_clr;
    logic        ev_ss, ev_lap, ev_clr;
    logic        act_ss, act_lap, act_clr;
    logic        do_clr, do_cap;
    logic        cnt_en, sat;
    logic [7:0]  m_q, s_q, cs_q;
    logic        cs_carry, s_carry, m_carry;
    logic [23:0] live, lap_reg;
    logic        ovf_r;

    // prev loads 1 in reset so a button held through reset makes no event
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_ss  <= 1'b1;
            prev_lap <= 1'b1;
            prev_clr <= 1'b1;
        end else begin
            prev_ss  <= sw.start_stop;
            prev_lap <= sw.lap;
            prev_clr <= sw.clear;
        end
    end

    assign ev_ss   = sw.start_stop & ~prev_ss;
    assign ev_lap  = sw.lap & ~prev_lap;
    assign ev_clr  = sw.clear & ~prev_clr;
    assign act_clr = ev_clr;
    assign act_ss  = ev_ss & ~ev_clr;
    assign act_lap = ev_lap & ~ev_clr & ~ev_ss;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        do_clr   = 1'b0;
        do_cap   = 1'b0;
        case (state)
            IDLE:  if (act_ss) state_nx = RUN;
            RUN: begin
                if (act_ss) begin
                    state_nx = PAUSE;
                end else if (act_lap) begin
                    state_nx = LAP;
                    do_cap   = 1'b1;
                end
            end
            LAP: begin
                if (act_ss)       state_nx = PAUSE;
                else if (act_lap) state_nx = RUN;
            end
            PAUSE: begin
                if (act_clr) begin
                    state_nx = IDLE;
                    do_clr   = 1'b1;
                end else if (act_ss) begin
                    state_nx = RUN;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // enable uses the pre-transition state
    assign cnt_en = sw.tick & ((state == RUN) || (state == LAP));
    assign live   = {m_q, s_q, cs_q};
    assign sat    = !WRAP_AT_MAX && (live == TIME_MAX);

    bcd_counter_2dig #(.TENS_MAX(CS_TENS_MAX)) u_cs (
        .clk(clk), .reset(reset), .clr(do_clr), .inc(cnt_en), .sat(sat),
        .q(cs_q), .carry(cs_carry));
    bcd_counter_2dig #(.TENS_MAX(SEC_TENS_MAX)) u_s (
        .clk(clk), .reset(reset), .clr(do_clr), .inc(cs_carry), .sat(sat),
        .q(s_q), .carry(s_carry));
    bcd_counter_2dig #(.TENS_MAX(MIN_TENS_MAX)) u_m (
        .clk(clk), .reset(reset), .clr(do_clr), .inc(s_carry), .sat(sat),
        .q(m_q), .carry(m_carry));

    always_ff @(posedge clk) begin
        if (reset || do_clr) lap_reg <= '0;
        else if (do_cap)     lap_reg <= live;
    end

    // m_carry marks a tick taken at 59:59.99; saturating mode also flags reaching it
    always_ff @(posedge clk) begin
        if (reset || do_clr)
            ovf_r <= 1'b0;
        else if (m_carry || (!WRAP_AT_MAX && cnt_en && (live == TIME_NEAR_MAX)))
            ovf_r <= 1'b1;
    end

    assign sw.running    = (state == RUN) || (state == LAP);
    assign sw.lap_frozen = (state == LAP);
    assign sw.ovf        = ovf_r;
    assign {sw.disp_m, sw.disp_s, sw.disp_cs} = (state == LAP) ? lap_reg : live;
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl; a saturating and a wrapping instance share stimulus.
module tb_stopwatch_ctrl;
    logic clk = 1'b0;
    logic reset, tick, ss, lp, clr;
    int   checks = 0;
    int   failures = 0;

    stopwatch_ctrl_if if0 ();
    stopwatch_ctrl_if if1 ();

    assign if0.tick = tick;  assign if0.start_stop = ss;
    assign if0.lap  = lp;    assign if0.clear      = clr;
    assign if1.tick = tick;  assign if1.start_stop = ss;
    assign if1.lap  = lp;    assign if1.clear      = clr;

    stopwatch_ctrl #(.WRAP_AT_MAX(1'b0)) dut0 (.clk(clk), .reset(reset), .sw(if0));
    stopwatch_ctrl #(.WRAP_AT_MAX(1'b1)) dut1 (.clk(clk), .reset(reset), .sw(if1));

    always #5 clk = ~clk;

    logic [23:0] d0, d1;
    assign d0 = {if0.disp_m, if0.disp_s, if0.disp_cs};
    assign d1 = {if1.disp_m, if1.disp_s, if1.disp_cs};

    task automatic step(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1; tick = 1'b0; ss = 1'b0; lp = 1'b0; clr = 1'b0;
        step(2);
        reset = 1'b0;
        step(1);
    endtask

    task automatic ticks(input int n);
        tick = 1'b1; step(n); tick = 1'b0;
    endtask

    task automatic press_ss();
        ss = 1'b1; step(1); ss = 1'b0; step(1);
    endtask

    task automatic press_lap();
        lp = 1'b1; step(1); lp = 1'b0; step(1);
    endtask

    task automatic press_clr();
        clr = 1'b1; step(1); clr = 1'b0; step(1);
    endtask

    task automatic test_reset();
        reset = 1'b1; tick = 1'b1; ss = 1'b0; lp = 1'b0; clr = 1'b0;
        step(2);
        checks++; if (if0.running !== 1'b0) begin failures++; $display("FAIL reset_running got=%b exp=0", if0.running); end
        checks++; if (if0.lap_frozen !== 1'b0) begin failures++; $display("FAIL reset_lap_frozen got=%b exp=0", if0.lap_frozen); end
        checks++; if (d0 !== 24'h000000) begin failures++; $display("FAIL reset_disp got=%h exp=000000", d0); end
        checks++; if (if0.ovf !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%b exp=0", if0.ovf); end
        tick = 1'b0; reset = 1'b0;
        step(1);
    endtask

    task automatic test_start_stop();
        do_reset();
        press_ss();
        checks++; if (if0.running !== 1'b1) begin failures++; $display("FAIL ss_start got=%b exp=1", if0.running); end
        ticks(150);
        press_ss();
        checks++; if (if0.running !== 1'b0) begin failures++; $display("FAIL ss_stop got=%b exp=0", if0.running); end
        checks++; if (d0 !== 24'h000150) begin failures++; $display("FAIL ss_disp got=%h exp=000150", d0); end
        ticks(1);
        checks++; if (d0 !== 24'h000150) begin failures++; $display("FAIL ss_paused_tick got=%h exp=000150", d0); end
    endtask

    task automatic test_lap();
        do_reset();
        press_ss();
        ticks(42);
        press_lap();
        checks++; if (if0.lap_frozen !== 1'b1) begin failures++; $display("FAIL lap_frozen got=%b exp=1", if0.lap_frozen); end
        ticks(10);
        checks++; if (d0 !== 24'h000042) begin failures++; $display("FAIL lap_hold got=%h exp=000042", d0); end
        checks++; if (if0.running !== 1'b1) begin failures++; $display("FAIL lap_running got=%b exp=1", if0.running); end
        press_lap();
        checks++; if (if0.lap_frozen !== 1'b0) begin failures++; $display("FAIL lap_release got=%b exp=0", if0.lap_frozen); end
        checks++; if (d0 !== 24'h000052) begin failures++; $display("FAIL lap_live got=%h exp=000052", d0); end
    endtask

    task automatic test_rollover();
        do_reset();
        press_ss();
        ticks(5999);
        press_ss();
        checks++; if (d0 !== 24'h005999) begin failures++; $display("FAIL roll_pause got=%h exp=005999", d0); end
        press_ss();
        ticks(1);
        checks++; if (d0 !== 24'h010000) begin failures++; $display("FAIL roll_min got=%h exp=010000", d0); end
        press_ss();
        press_clr();
        checks++; if (if0.running !== 1'b0) begin failures++; $display("FAIL clr_running got=%b exp=0", if0.running); end
        checks++; if (d0 !== 24'h000000) begin failures++; $display("FAIL clr_disp got=%h exp=000000", d0); end
        checks++; if (if0.ovf !== 1'b0) begin failures++; $display("FAIL clr_ovf got=%b exp=0", if0.ovf); end
        press_lap();
        ticks(4);
        checks++; if ({if0.running, d0} !== 25'h0_000000) begin failures++; $display("FAIL idle_hold got=%h exp=0000000", {if0.running, d0}); end
    endtask

    task automatic test_priority();
        do_reset();
        press_ss();
        ticks(5);
        ss = 1'b1; tick = 1'b1; step(1); ss = 1'b0; tick = 1'b0;
        checks++; if (if0.running !== 1'b0) begin failures++; $display("FAIL ss_tick_state got=%b exp=0", if0.running); end
        checks++; if (d0 !== 24'h000006) begin failures++; $display("FAIL ss_tick_disp got=%h exp=000006", d0); end
        step(1);
        ss = 1'b1; tick = 1'b1; step(1); ss = 1'b0; tick = 1'b0;
        checks++; if ({if0.running, d0} !== 25'h1_000006) begin failures++; $display("FAIL resume_tick got=%h exp=1000006", {if0.running, d0}); end
        step(1);
        press_ss();
        clr = 1'b1; ss = 1'b1; step(1); clr = 1'b0; ss = 1'b0; step(1);
        checks++; if ({if0.running, d0} !== 25'h0_000000) begin failures++; $display("FAIL clr_over_ss got=%h exp=0000000", {if0.running, d0}); end
        ticks(3);
        checks++; if (d0 !== 24'h000000) begin failures++; $display("FAIL clr_idle got=%h exp=000000", d0); end
        press_ss();
        checks++; if (if0.running !== 1'b1) begin failures++; $display("FAIL idle_start got=%b exp=1", if0.running); end
    endtask

    task automatic test_saturate();
        do_reset();
        press_ss();
        force dut0.u_m.q = 8'h59;  force dut0.u_s.q = 8'h59;  force dut0.u_cs.q = 8'h98;
        force dut1.u_m.q = 8'h59;  force dut1.u_s.q = 8'h59;  force dut1.u_cs.q = 8'h98;
        step(1);
        release dut0.u_m.q;  release dut0.u_s.q;  release dut0.u_cs.q;
        release dut1.u_m.q;  release dut1.u_s.q;  release dut1.u_cs.q;
        step(1);
        checks++; if ({d0, d1} !== 48'h595998_595998) begin failures++; $display("FAIL preload got=%h exp=595998595998", {d0, d1}); end
        ticks(1);
        checks++; if ({if0.ovf, d0} !== 25'h1_595999) begin failures++; $display("FAIL sat_reach got=%h exp=1595999", {if0.ovf, d0}); end
        ticks(2);
        checks++; if ({if0.ovf, d0} !== 25'h1_595999) begin failures++; $display("FAIL sat_hold got=%h exp=1595999", {if0.ovf, d0}); end
        checks++; if ({if1.ovf, d1} !== 25'h1_000001) begin failures++; $display("FAIL wrap got=%h exp=1000001", {if1.ovf, d1}); end
        press_ss();
        checks++; if (if0.running !== 1'b0) begin failures++; $display("FAIL sat_buttons got=%b exp=0", if0.running); end
        checks++; if ({if0.ovf, d0} !== 25'h1_595999) begin failures++; $display("FAIL ovf_sticky got=%h exp=1595999", {if0.ovf, d0}); end
    endtask

    task automatic test_reset_mid();
        press_ss();
        tick = 1'b1; step(3);
        reset = 1'b1; step(1);
        checks++; if ({if0.running, if0.lap_frozen, if0.ovf, d0} !== 27'h0) begin failures++; $display("FAIL reset_mid got=%h exp=0", {if0.running, if0.lap_frozen, if0.ovf, d0}); end
        checks++; if ({if1.ovf, d1} !== 25'h0) begin failures++; $display("FAIL reset_mid_wrap got=%h exp=0", {if1.ovf, d1}); end
        tick = 1'b0; reset = 1'b0; step(1);
    endtask

    task automatic test_held_reset();
        reset = 1'b1; ss = 1'b1; lp = 1'b1; tick = 1'b0; clr = 1'b0;
        step(2);
        reset = 1'b0;
        step(3);
        checks++; if (if0.running !== 1'b0) begin failures++; $display("FAIL held_btn got=%b exp=0", if0.running); end
        ss = 1'b0; lp = 1'b0; step(1);
        press_ss();
        checks++; if (if0.running !== 1'b1) begin failures++; $display("FAIL held_then_press got=%b exp=1", if0.running); end
    endtask

    initial begin
        test_reset();
        test_start_stop();
        test_lap();
        test_rollover();
        test_priority();
        test_saturate();
        test_reset_mid();
        test_held_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
